// File: rtl/inst_mem_loader.sv
// Instruction memory loader: accepts a program over a valid/ready stream,
// stores it in on-chip storage, then serves fetches combinationally to the
// processor's program counter.
module inst_mem_loader #(
  parameter int          AW        = 8,
  parameter int          DEPTH     = 256,
  parameter logic [15:0] FILL_INST = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [15:0]   ld_data,
  input  logic          ld_last,
  input  logic [AW-1:0] pc,
  output logic [15:0]   inst,
  output logic          run,
  output logic          err,
  output logic [AW:0]   ld_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Count value at which one more non-final word fills the storage.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  state_t      state;
  state_t      state_nxt;
  logic [AW:0] count_nxt;
  logic        wr_en;

  // Instruction storage; never reset, a new load overwrites it.
  logic [15:0] mem [DEPTH];

  // State and word-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ld_count <= '0;
    end else begin
      state    <= state_nxt;
      ld_count <= count_nxt;
    end
  end

  // Next-state, word counting, write enable and status outputs.
  always_comb begin
    state_nxt = state;
    count_nxt = ld_count;
    wr_en     = 1'b0;
    ld_ready  = 1'b0;
    run       = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: begin
        if (ld_start) begin
          state_nxt = LOAD;
          count_nxt = '0;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        // A restart wins over a word presented in the same cycle.
        if (ld_start) begin
          count_nxt = '0;
        end else if (ld_valid) begin
          wr_en     = 1'b1;
          count_nxt = ld_count + ONE;
          if (ld_last) begin
            state_nxt = RUN;
          end else if (ld_count == LAST_IDX) begin
            state_nxt = ERR;
          end
        end
      end
      RUN: begin
        run = 1'b1;
        if (ld_start) begin
          state_nxt = LOAD;
          count_nxt = '0;
        end
      end
      ERR: begin
        err = 1'b1;
        if (ld_start) begin
          state_nxt = LOAD;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Synchronous write port; only active in LOAD, where ld_count < DEPTH.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ld_count[AW-1:0]] <= ld_data;
    end
  end

  // Zero-latency fetch: the core registers inst_in itself, so no flop here.
  always_comb begin
    inst = FILL_INST;
    if ((state == RUN) && ({1'b0, pc} < ld_count)) begin
      inst = mem[pc];
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized and directed bench for inst_mem_loader with a behavioural
// program-memory model.
module tb_inst_mem_loader;

  localparam int          AW    = 8;
  localparam int          DEPTH = 256;
  localparam logic [15:0] FILL  = 16'h0000;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_ERR  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_start;
  logic          ld_valid;
  logic          ld_ready;
  logic [15:0]   ld_data;
  logic          ld_last;
  logic [AW-1:0] pc;
  logic [15:0]   inst;
  logic          run;
  logic          err;
  logic [AW:0]   ld_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode, words stored in the current load, program image.
  int          mdl_mode;
  int          mdl_cnt;
  logic [15:0] mdl_mem [DEPTH];

  inst_mem_loader #(.AW(AW), .DEPTH(DEPTH), .FILL_INST(FILL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .pc       (pc),
    .inst     (inst),
    .run      (run),
    .err      (err),
    .ld_count (ld_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_mode = M_IDLE;
    mdl_cnt  = 0;
  endtask

  // Apply one clock edge of the load protocol to the model.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (ld_start) begin
      mdl_mode = M_LOAD;
      mdl_cnt  = 0;
    end else if (mdl_mode == M_LOAD && ld_valid) begin
      mdl_mem[mdl_cnt] = ld_data;
      mdl_cnt++;
      if (ld_last)            mdl_mode = M_RUN;
      else if (mdl_cnt == DEPTH) mdl_mode = M_ERR;
    end
  endtask

  task automatic check_outputs();
    logic [15:0] exp_inst;
    exp_inst = FILL;
    if (mdl_mode == M_RUN && int'(pc) < mdl_cnt) exp_inst = mdl_mem[pc];
    check_val("ld_ready", 32'(ld_ready), 32'(mdl_mode == M_LOAD));
    check_val("run",      32'(run),      32'(mdl_mode == M_RUN));
    check_val("err",      32'(err),      32'(mdl_mode == M_ERR));
    check_val("ld_count", 32'(ld_count), 32'(mdl_cnt));
    check_val("inst",     32'(inst),     32'(exp_inst));
  endtask

  // Drive one cycle of inputs after the falling edge, check, then clock it.
  task automatic step(input bit s, input bit v, input logic [15:0] d,
                      input bit l, input logic [AW-1:0] p);
    @(negedge clk);
    ld_start = s;
    ld_valid = v;
    ld_data  = d;
    ld_last  = l;
    pc       = p;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
  endtask

  task automatic load_prog(input int n, input bit with_last);
    step(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 16'($urandom), with_last && (i == n - 1), 8'($urandom));
    end
  endtask

  task automatic sweep_pc(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(1'b0, 1'($urandom), 16'($urandom), 1'($urandom), 8'(i));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    pc       = '0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    model_reset();

    // Reset state
    step(1'b0, 1'b1, 16'h1111, 1'b0, 8'h0);
    step(1'b0, 1'b1, 16'h2222, 1'b1, 8'h1);
    #2 rst_n = 1'b1;

    // Three-word program
    step(1'b1, 1'b0, 16'h0000, 1'b0, 8'h0);
    step(1'b0, 1'b1, 16'h1001, 1'b0, 8'h0);
    step(1'b0, 1'b1, 16'h2002, 1'b0, 8'h0);
    step(1'b0, 1'b1, 16'h3003, 1'b1, 8'h0);
    sweep_pc(0, 4);
    check_val("t1_word2", 32'(mdl_mem[2]), 32'h3003);

    // Gaps in ld_valid
    step(1'b1, 1'b0, 16'h0000, 1'b0, 8'h0);
    step(1'b0, 1'b1, 16'hA5A5, 1'b0, 8'h0);
    step(1'b0, 1'b0, 16'hDEAD, 1'b1, 8'h0);
    step(1'b0, 1'b1, 16'h5A5A, 1'b1, 8'h0);
    sweep_pc(0, 3);

    // Overflow without ld_last, then recovery
    load_prog(DEPTH, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'($urandom), 1'b1, 8'($urandom));
    step(1'b0, 1'b0, 16'h0, 1'b0, 8'hFF);
    step(1'b1, 1'b1, 16'h7777, 1'b1, 8'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);

    // Reload from RUN
    load_prog(4, 1'b1);
    sweep_pc(0, 5);
    step(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
    step(1'b0, 1'b1, 16'hBEEF, 1'b1, 8'h0);
    sweep_pc(0, 2);

    // Asynchronous reset in the middle of a load
    load_prog(2, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    step(1'b0, 1'b1, 16'h4444, 1'b0, 8'h0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'($urandom), 1'b1, 8'(i));

    // Restart coincident with a valid word
    step(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    step(1'b0, 1'b1, 16'h1234, 1'b0, 8'h0);
    step(1'b1, 1'b1, 16'h5678, 1'b1, 8'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
    step(1'b0, 1'b1, 16'h9ABC, 1'b1, 8'h0);
    sweep_pc(0, 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] p;
      p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      step($urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7, 16'($urandom),
           $urandom_range(0, 11) == 0, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
